fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 25 ++
 rtl/fetch_ctrl_buf.sv | 55 +++++
 rtl/fetch_ctrl.sv | 105 ++++++++++
 tb/tb_fetch_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Holds the pc/instruction word types, the FSM state enum and the buffer entry layout.
package fetch_ctrl_pkg;

  typedef logic [15:0] pc_t;
  typedef logic [15:0] inst_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  localparam pc_t RESET_PC_DEFAULT = 16'h0000;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    pc_t   pc;
    inst_t inst;
  } fetch_entry_t;

  function automatic pc_t pc_inc(input pc_t pc);
    return pc + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_ctrl_buf.sv
// Two-entry FIFO of {pc, inst} records between instruction memory and decode.
// Clear dominates push/pop; push and pop in the same cycle both take effect.
module fetch_buf
  import fetch_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  fetch_entry_t i_entry,
  input  logic         i_pop,
  input  logic         i_clear,
  output logic [1:0]   o_count,
  output fetch_entry_t o_head
);

  fetch_entry_t r_mem [2];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_count;

  logic w_do_pop;
  logic w_do_push;

  assign w_do_pop  = i_pop && (r_count != 2'd0);
  assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage itself is reset because the head word is a visible
      // output that must read zero while reset is held.
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_clear) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_entry;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues sequential reads, buffers returned words
// for decode and redirects on a taken branch, discarding anything in flight.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter pc_t RESET_PC  = RESET_PC_DEFAULT,
  parameter int  BUF_DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  jmp_true,
  input  pc_t   jmp_tgt,
  input  logic  stall,
  output logic  imem_req,
  output pc_t   imem_addr,
  input  inst_t imem_rdata,
  output inst_t inst,
  output pc_t   inst_pc,
  output logic  inst_valid,
  output logic  flush
);

  localparam logic [2:0] DEPTH = 3'(BUF_DEPTH);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  pc_t          r_pc;
  pc_t          r_resp_pc;
  logic         r_inflight;
  logic         r_flush;

  logic         w_run;
  logic         w_jmp;
  logic         w_pop;
  logic         w_req;
  logic [2:0]   w_occ;
  logic [1:0]   w_count;
  fetch_entry_t w_head;
  fetch_entry_t w_entry;

  assign w_run = (r_state == RUN);
  assign w_jmp = jmp_true && w_run;
  assign w_pop = inst_valid && !stall;

  // Words already buffered plus the one still returning, after this cycle's pop.
  assign w_occ = {1'b0, w_count} - {2'b0, w_pop} + {2'b0, r_inflight};

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    w_state_nxt = r_state;
    w_req       = 1'b0;
    unique case (r_state)
      IDLE: w_state_nxt = RUN;
      RUN:  w_req       = (w_occ < DEPTH);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_resp_pc  <= '0;
      r_inflight <= 1'b0;
      r_flush    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // pre-edge values regardless of statement order.
      r_state <= w_state_nxt;
      r_flush <= w_jmp;
      if (w_jmp) begin
        r_pc       <= jmp_tgt;
        r_inflight <= 1'b0;
      end else begin
        r_inflight <= w_req;
        if (w_req) begin
          r_pc      <= pc_inc(r_pc);
          r_resp_pc <= r_pc;
        end
      end
    end
  end

  assign w_entry = '{pc: r_resp_pc, inst: imem_rdata};

  // A redirect clears the buffer, which also drops the word returning this cycle.
  fetch_buf u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_entry (w_entry),
    .i_pop   (w_pop),
    .i_clear (w_jmp),
    .o_count (w_count),
    .o_head  (w_head)
  );

  assign inst_valid = (w_count != 2'd0);
  assign inst       = w_head.inst;
  assign inst_pc    = w_head.pc;
  assign imem_req   = w_req;
  assign imem_addr  = r_pc;
  assign flush      = r_flush;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table, hand-written corner
// sequences and a random run, all scored against an instruction-stream model.
module tb_fetch_ctrl;

  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        jmp_true = 1'b0;
  logic [15:0] jmp_tgt = 16'h0000;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = 16'hDEAD;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        inst_valid;
  logic        flush;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .jmp_true   (jmp_true),
    .jmp_tgt    (jmp_tgt),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .flush      (flush)
  );

  // Instruction memory: word at address a is a ^ key, returned one cycle after the request.
  logic [15:0] key = 16'h0000;
  always @(posedge clk) imem_rdata <= imem_req ? (imem_addr ^ key) : 16'hDEAD;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream model: edges since reset release / since last accepted redirect,
  // next fetch address expected, next instruction address decode should receive.
  int          s_cnt;
  int          j_cnt;
  logic [15:0] m_fetch;
  logic [15:0] m_exp;
  logic        prev_stall;
  logic        prev_vexp;

  task automatic model_init();
    s_cnt      = 0;
    j_cnt      = 100;
    m_fetch    = RST_PC;
    m_exp      = RST_PC;
    prev_stall = 1'b0;
    prev_vexp  = 1'b0;
  endtask

  task automatic model_cycle();
    logic vexp;
    logic run;
    logic acc;
    vexp = (s_cnt >= 3) && (j_cnt >= 3);
    run  = (s_cnt >= 1);
    acc  = jmp_true && run;
    check("inst_valid", {15'd0, inst_valid}, {15'd0, vexp});
    check("flush", {15'd0, flush}, {15'd0, (j_cnt == 1)});
    if (!run) check("idle_req", {15'd0, imem_req}, 16'd0);
    if (j_cnt == 1) check("flush_req", {15'd0, imem_req}, 16'd1);
    if (imem_req) check("imem_addr", imem_addr, m_fetch);
    if (stall && prev_stall && vexp && prev_vexp) check("full_req", {15'd0, imem_req}, 16'd0);
    if (inst_valid && !stall && !acc) begin
      check("inst_pc", inst_pc, m_exp);
      check("inst", inst, m_exp ^ key);
      m_exp = m_exp + 16'd1;
    end
    if (acc) begin
      m_fetch = jmp_tgt;
      m_exp   = jmp_tgt;
      j_cnt   = 1;
    end else begin
      if (imem_req) m_fetch = m_fetch + 16'd1;
      if (j_cnt < 100) j_cnt++;
    end
    if (s_cnt < 100) s_cnt++;
    prev_stall = stall;
    prev_vexp  = vexp;
  endtask

  task automatic step(input logic j, input logic [15:0] t, input logic s);
    @(negedge clk);
    jmp_true = j;
    jmp_tgt  = t;
    stall    = s;
    #1;
    model_cycle();
  endtask

  task automatic check_reset();
    check("rst_req", {15'd0, imem_req}, 16'd0);
    check("rst_addr", imem_addr, RST_PC);
    check("rst_inst", inst, 16'h0000);
    check("rst_inst_pc", inst_pc, 16'h0000);
    check("rst_valid", {15'd0, inst_valid}, 16'd0);
    check("rst_flush", {15'd0, flush}, 16'd0);
  endtask

  // Release reset at a falling edge with a redirect request that IDLE must ignore.
  task automatic release_step();
    model_init();
    @(negedge clk);
    rst_n    = 1'b1;
    jmp_true = 1'b1;
    jmp_tgt  = 16'h1234;
    stall    = 1'b0;
    #1;
    model_cycle();
  endtask

  typedef struct {
    logic        jmp;
    logic [15:0] tgt;
    logic        stl;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_pc;
    logic        e_flush;
  } vec_t;

  vec_t vec [13];

  initial begin
    // Row i is the cycle after i edges since reset release.
    vec[0]  = '{1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vec[1]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vec[2]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 16'h0000, 1'b0};
    vec[3]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0002, 1'b1, 16'h0000, 1'b0};
    vec[4]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0003, 1'b1, 16'h0001, 1'b0};
    vec[5]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0004, 1'b1, 16'h0002, 1'b0};
    vec[6]  = '{1'b1, 16'hFFFE, 1'b0, 1'b1, 16'h0005, 1'b1, 16'h0003, 1'b0};
    vec[7]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFFE, 1'b0, 16'h0000, 1'b1};
    vec[8]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 1'b0};
    vec[9]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 16'hFFFE, 1'b0};
    vec[10] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b1, 16'hFFFF, 1'b0};
    vec[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0002, 1'b1, 16'h0000, 1'b0};
    vec[12] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0003, 1'b1, 16'h0001, 1'b0};

    #1 rst_n = 1'b0;
    #1 check_reset();
    repeat (2) @(negedge clk);
    model_init();

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (i == 0) rst_n = 1'b1;
      jmp_true = vec[i].jmp;
      jmp_tgt  = vec[i].tgt;
      stall    = vec[i].stl;
      #1;
      model_cycle();
      check("vec_req", {15'd0, imem_req}, {15'd0, vec[i].e_req});
      check("vec_addr", imem_addr, vec[i].e_addr);
      check("vec_valid", {15'd0, inst_valid}, {15'd0, vec[i].e_valid});
      check("vec_flush", {15'd0, flush}, {15'd0, vec[i].e_flush});
      if (vec[i].e_valid) begin
        check("vec_inst_pc", inst_pc, vec[i].e_pc);
        check("vec_inst", inst, vec[i].e_pc);
      end
    end

    // Long stall fills the buffer; the stream must resume without loss or duplication.
    repeat (5) step(1'b0, 16'h0000, 1'b1);
    check("stall_full_req", {15'd0, imem_req}, 16'd0);
    check("stall_hold_pc", inst_pc, m_exp);
    repeat (6) step(1'b0, 16'h0000, 1'b0);

    // Redirect while a response is in flight.
    step(1'b1, 16'h0040, 1'b0);
    step(1'b0, 16'h0000, 1'b0);
    check("redir_flush", {15'd0, flush}, 16'd1);
    check("redir_addr", imem_addr, 16'h0040);
    repeat (5) step(1'b0, 16'h0000, 1'b0);

    // Redirect with stall asserted: redirect wins.
    step(1'b1, 16'h0100, 1'b1);
    repeat (3) step(1'b0, 16'h0000, 1'b0);
    check("stall_redir_pc", inst_pc, 16'h0100);

    // Back-to-back redirects: last target wins.
    step(1'b1, 16'h0200, 1'b0);
    step(1'b1, 16'h0300, 1'b0);
    repeat (4) step(1'b0, 16'h0000, 1'b0);

    // Reset asserted mid-stream with a full buffer.
    repeat (3) step(1'b0, 16'h0000, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset();
    repeat (2) @(negedge clk);
    check_reset();
    key = 16'h5A3C;
    release_step();

    for (int i = 0; i < 3000; i++) begin
      logic        rj;
      logic [15:0] rt;
      logic        rs;
      rj = ($urandom_range(0, 19) == 0);
      rt = ($urandom_range(0, 3) == 0) ? (16'hFFF0 + 16'($urandom_range(0, 15))) : 16'($urandom);
      rs = ($urandom_range(0, 9) < 3);
      step(rj, rt, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
